ysyx_22040632_ifu_fetch: RTL and testbench
==========================================

// Module: ysyx_22040632_ifu_fetch
// PURPOSE
//  Instruction-fetch stage directly upstream of the I-cache. Owns the PC, issues fetch
//  requests on the ifu side of the if2ic handshake, extracts the 32-bit instruction from
//  the returned 128-bit line (or 64-bit uncacheable beat), and hands it to decode over a
//  valid/ready port. Accepts redirects (branch/jump/trap) and squashes in-flight fetches.
// PARAMETERS
//  RESET_PC      32'h8000_0000  PC of first fetch after reset
//  UNC_BASE      32'h0000_0000  first address of uncacheable window (inclusive)
//  UNC_LIMIT     32'h7fff_ffff  last address of uncacheable window (inclusive)
// PORTS
//  clk                  in   1    clock, all state on rising edge
//  rst_n                in   1    asynchronous reset, active-low
//  ic_pc                out  32   fetch address to I-cache (if2ic.pc)
//  ic_valid             out  1    fetch request valid (if2ic.valid)
//  ic_uncacheable       out  1    request bypasses cache (if2ic.uncacheable)
//  ic_ready             in   1    one-cycle pulse: response data valid this cycle
//  ic_inst              in   128  cacheable line data, word k at bits [32k+31:32k]
//  ic_inst_uncacheable  in   64   uncacheable beat, word k at bits [32k+31:32k]
//  redirect_valid       in   1    one-cycle pulse: replace PC with redirect_pc
//  redirect_pc          in   32   redirect target
//  id_valid             out  1    instruction available to decode
//  id_ready             in   1    decode accepts instruction
//  id_pc                out  32   PC of id_inst
//  id_inst              out  32   instruction word
// BEHAVIOUR
//  - Reset (async assert, sync release): pc=RESET_PC, state=IDLE, kill=0, ic_valid=0,
//    id_valid=0, id_inst=0, id_pc=RESET_PC, ic_pc=RESET_PC, ic_uncacheable=0.
//  - States: IDLE -> FETCH unconditionally after one cycle.
//    FETCH: ic_valid=1, ic_pc=pc, ic_uncacheable=(UNC_BASE<=pc<=UNC_LIMIT).
//      ic_valid, ic_pc, ic_uncacheable held stable until the ic_ready cycle (never
//      withdrawn, even on redirect). On ic_ready & !kill & !redirect_valid -> HOLD,
//      capture id_inst = uncacheable ? ic_inst_uncacheable word pc[2]
//      : ic_inst word pc[3:2]; id_pc=pc. On ic_ready & (kill|redirect_valid): drop
//      data, kill=0, stay FETCH with new pc (issued next cycle, ic_valid stays 1).
//    HOLD: id_valid=1, ic_valid=0. On id_valid&id_ready: pc=pc+4 -> FETCH.
//  - Latency: request visible the cycle after entering FETCH; id_valid the cycle after
//    ic_ready. Max throughput one instruction per 2 cycles (no prefetch).
//  - Redirect: pc <= {redirect_pc[31:2],2'b00} in any state.
//    IDLE: target used for first fetch. FETCH, no ic_ready same cycle: kill=1, current
//    response discarded when it arrives. HOLD: id_valid drops next cycle, -> FETCH;
//    redirect wins over a same-cycle id handshake (instruction counts as consumed,
//    pc still takes redirect target, not pc+4).
//  - Back-to-back redirects: last one wins; kill stays 1 until one response dropped.
//  - PC arithmetic 32-bit, wraps 32'hffff_fffc -> 32'h0000_0000, no flag.
//  - Uncacheable classification evaluated on the issued pc only; cacheable word select
//    uses pc[3:2], uncacheable uses pc[2]; other bits of the response ignored.
//  - id_pc/id_inst hold their value while id_valid=0 (no reset to X after use).
//  - rst_n assert mid-fetch: state returns to IDLE immediately; any later ic_ready is
//    ignored in IDLE (I-cache is reset by the same rst_n).
// TESTING
//  1 Reset release, ic_ready 2 cycles after ic_valid with ic_inst word0=32'h00000413
//    -> ic_pc=8000_0000, id_valid=1 id_inst=00000413 id_pc=8000_0000 next cycle.
//  2 Sequential: id_ready=1 always, lines returned -> id_pc 8000_0000,..04,..08,..0c,
//    ..10 selecting words 0,1,2,3,0; ic_pc stable while ic_valid & !ic_ready.
//  3 Redirect to 8000_0102 during FETCH (ic_ready 3 cycles later) -> that response
//    dropped, next ic_pc=8000_0100, id_pc=8000_0100, word 0 of new line.
//  4 Redirect to 0000_1004 while HOLD with id_ready=0 -> id_valid low next cycle,
//    ic_uncacheable=1, id_inst=ic_inst_uncacheable[63:32].
//  5 Decode stall: id_ready=0 for 10 cycles in HOLD -> id_valid/id_inst/id_pc stable,
//    ic_valid=0; on id_ready=1 next fetch pc+4.
//  6 rst_n low during FETCH, ic_ready pulsed while in reset/IDLE -> no id_valid; fetch
//    restarts at RESET_PC.

Source files
------------

// File: rtl/ysyx_22040632_ifu_fetch.sv
// Instruction-fetch stage: owns the PC, issues single outstanding requests to the I-cache,
// extracts the addressed word from the response and presents it to decode.
module ysyx_22040632_ifu_fetch #(
    parameter logic [31:0] RESET_PC  = 32'h8000_0000,
    parameter logic [31:0] UNC_BASE  = 32'h0000_0000,
    parameter logic [31:0] UNC_LIMIT = 32'h7fff_ffff
) (
    input  logic         clk,
    input  logic         rst_n,
    output logic [31:0]  ic_pc,
    output logic         ic_valid,
    output logic         ic_uncacheable,
    input  logic         ic_ready,
    input  logic [127:0] ic_inst,
    input  logic [63:0]  ic_inst_uncacheable,
    input  logic         redirect_valid,
    input  logic [31:0]  redirect_pc,
    output logic         id_valid,
    input  logic         id_ready,
    output logic [31:0]  id_pc,
    output logic [31:0]  id_inst
);

    localparam int unsigned XLEN = 32;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_HOLD  = 2'd2
    } state_t;

    state_t            r_state;
    logic [XLEN-1:0]   r_pc;
    logic              r_kill;

    logic [XLEN-1:0]   w_redir_pc;
    logic [XLEN-1:0]   w_tgt_pc;
    logic [XLEN-1:0]   w_hold_pc;
    logic [XLEN-1:0]   w_word_c;
    logic [XLEN-1:0]   w_word_u;
    logic              w_unused_ok;

    // Offset-based range check: correct for any UNC_BASE <= UNC_LIMIT, no zero compare.
    function automatic logic is_unc(input logic [XLEN-1:0] a);
        return (a - UNC_BASE) <= (UNC_LIMIT - UNC_BASE);
    endfunction

    assign w_redir_pc  = {redirect_pc[XLEN-1:2], 2'b00};
    assign w_tgt_pc    = redirect_valid ? w_redir_pc : r_pc;
    assign w_hold_pc   = redirect_valid ? w_redir_pc : r_pc + XLEN'(4);
    assign w_word_c    = ic_inst[{r_pc[3:2], 5'd0} +: XLEN];
    assign w_word_u    = ic_inst_uncacheable[{r_pc[2], 5'd0} +: XLEN];
    assign w_unused_ok = ^redirect_pc[1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= S_IDLE;
            r_pc           <= RESET_PC;
            r_kill         <= 1'b0;
            ic_valid       <= 1'b0;
            ic_pc          <= RESET_PC;
            ic_uncacheable <= 1'b0;
            id_valid       <= 1'b0;
            id_pc          <= RESET_PC;
            id_inst        <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_state        <= S_FETCH;
                    r_pc           <= w_tgt_pc;
                    ic_valid       <= 1'b1;
                    ic_pc          <= w_tgt_pc;
                    ic_uncacheable <= is_unc(w_tgt_pc);
                end
                S_FETCH: begin
                    if (ic_ready) begin
                        if (r_kill || redirect_valid) begin
                            // Stale response: drop it and reissue at the current target.
                            r_kill         <= 1'b0;
                            r_pc           <= w_tgt_pc;
                            ic_pc          <= w_tgt_pc;
                            ic_uncacheable <= is_unc(w_tgt_pc);
                        end else begin
                            r_state  <= S_HOLD;
                            ic_valid <= 1'b0;
                            id_valid <= 1'b1;
                            id_pc    <= r_pc;
                            id_inst  <= ic_uncacheable ? w_word_u : w_word_c;
                        end
                    end else if (redirect_valid) begin
                        // Request stays on the bus unchanged; its response will be dropped.
                        r_pc   <= w_redir_pc;
                        r_kill <= 1'b1;
                    end
                end
                S_HOLD: begin
                    if (redirect_valid || id_ready) begin
                        r_state        <= S_FETCH;
                        r_pc           <= w_hold_pc;
                        ic_valid       <= 1'b1;
                        ic_pc          <= w_hold_pc;
                        ic_uncacheable <= is_unc(w_hold_pc);
                        id_valid       <= 1'b0;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ysyx_22040632_ifu_fetch.sv
// Directed bench for the fetch stage: hand-computed vectors checked with immediate assertions.
module tb_ysyx_22040632_ifu_fetch;

    logic         clk;
    logic         rst_n;
    logic [31:0]  ic_pc;
    logic         ic_valid;
    logic         ic_uncacheable;
    logic         ic_ready;
    logic [127:0] ic_inst;
    logic [63:0]  ic_inst_uncacheable;
    logic         redirect_valid;
    logic [31:0]  redirect_pc;
    logic         id_valid;
    logic         id_ready;
    logic [31:0]  id_pc;
    logic [31:0]  id_inst;

    int n_cmp  = 0;
    int n_fail = 0;

    ysyx_22040632_ifu_fetch dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .ic_pc               (ic_pc),
        .ic_valid            (ic_valid),
        .ic_uncacheable      (ic_uncacheable),
        .ic_ready            (ic_ready),
        .ic_inst             (ic_inst),
        .ic_inst_uncacheable (ic_inst_uncacheable),
        .redirect_valid      (redirect_valid),
        .redirect_pc         (redirect_pc),
        .id_valid            (id_valid),
        .id_ready            (id_ready),
        .id_pc               (id_pc),
        .id_inst             (id_inst)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic respond(input logic [127:0] line, input logic [63:0] beat);
        ic_ready            = 1'b1;
        ic_inst             = line;
        ic_inst_uncacheable = beat;
        step();
        ic_ready            = 1'b0;
    endtask

    task automatic redirect(input logic [31:0] tgt);
        redirect_valid = 1'b1;
        redirect_pc    = tgt;
        step();
        redirect_valid = 1'b0;
    endtask

    function automatic logic [127:0] mk_line(input logic [31:0] w0, input logic [31:0] w1,
                                             input logic [31:0] w2, input logic [31:0] w3);
        return {w3, w2, w1, w0};
    endfunction

    initial begin
        logic [127:0] line;
        logic [31:0]  exp_pc;
        logic [31:0]  exp_inst;
        int           wait_cnt;

        rst_n               = 1'b0;
        ic_ready            = 1'b0;
        ic_inst             = '0;
        ic_inst_uncacheable = '0;
        redirect_valid      = 1'b0;
        redirect_pc         = '0;
        id_ready            = 1'b0;

        // 1: reset values, then first fetch
        step();
        chk("rst_ic_valid", 32'(ic_valid), 32'd0);
        chk("rst_id_valid", 32'(id_valid), 32'd0);
        chk("rst_ic_pc", ic_pc, 32'h8000_0000);
        chk("rst_id_pc", id_pc, 32'h8000_0000);
        chk("rst_id_inst", id_inst, 32'h0);
        chk("rst_ic_unc", 32'(ic_uncacheable), 32'd0);
        rst_n = 1'b1;
        wait_cnt = 0;
        while (!ic_valid && wait_cnt < 16) begin
            step();
            wait_cnt++;
        end
        chk("t1_req_valid", 32'(ic_valid), 32'd1);
        chk("t1_ic_pc", ic_pc, 32'h8000_0000);
        chk("t1_ic_unc", 32'(ic_uncacheable), 32'd0);
        step();
        chk("t1_ic_pc_hold", ic_pc, 32'h8000_0000);
        respond(mk_line(32'h0000_0413, 32'h1111_1111, 32'h2222_2222, 32'h3333_3333), 64'h0);
        chk("t1_id_valid", 32'(id_valid), 32'd1);
        chk("t1_id_inst", id_inst, 32'h0000_0413);
        chk("t1_id_pc", id_pc, 32'h8000_0000);
        chk("t1_ic_valid_lo", 32'(ic_valid), 32'd0);

        // 2: sequential stream with decode always ready
        id_ready = 1'b1;
        step();
        for (int k = 1; k <= 4; k++) begin
            exp_pc = 32'h8000_0000 + 32'(4 * k);
            for (int j = 0; j < 4; j++) line[32*j +: 32] = 32'hA000_0000 | 32'(k << 8) | 32'(j);
            exp_inst = 32'hA000_0000 | 32'(k << 8) | 32'(k % 4);
            chk("t2_req_valid", 32'(ic_valid), 32'd1);
            chk("t2_ic_pc", ic_pc, exp_pc);
            step();
            chk("t2_ic_pc_stable", ic_pc, exp_pc);
            respond(line, 64'h0);
            chk("t2_id_valid", 32'(id_valid), 32'd1);
            chk("t2_id_pc", id_pc, exp_pc);
            chk("t2_id_inst", id_inst, exp_inst);
            step();
        end
        id_ready = 1'b0;

        // 3: redirect during FETCH, response three cycles later is dropped
        chk("t3_ic_pc_pre", ic_pc, 32'h8000_0014);
        redirect(32'h8000_0102);
        chk("t3_ic_pc_held", ic_pc, 32'h8000_0014);
        chk("t3_ic_valid_held", 32'(ic_valid), 32'd1);
        step();
        step();
        respond(mk_line(32'hDEAD_0000, 32'hDEAD_0001, 32'hDEAD_0002, 32'hDEAD_0003), 64'h0);
        chk("t3_drop_id_valid", 32'(id_valid), 32'd0);
        chk("t3_reissue_valid", 32'(ic_valid), 32'd1);
        chk("t3_reissue_pc", ic_pc, 32'h8000_0100);
        respond(mk_line(32'hB000_0100, 32'hB000_0104, 32'hB000_0108, 32'hB000_010C), 64'h0);
        chk("t3_id_valid", 32'(id_valid), 32'd1);
        chk("t3_id_pc", id_pc, 32'h8000_0100);
        chk("t3_id_inst", id_inst, 32'hB000_0100);

        // 5: decode stall holds the presented instruction
        for (int c = 0; c < 10; c++) begin
            step();
            chk("t5_id_valid", 32'(id_valid), 32'd1);
            chk("t5_id_inst", id_inst, 32'hB000_0100);
            chk("t5_id_pc", id_pc, 32'h8000_0100);
            chk("t5_ic_valid", 32'(ic_valid), 32'd0);
        end
        id_ready = 1'b1;
        step();
        id_ready = 1'b0;
        chk("t5_next_valid", 32'(ic_valid), 32'd1);
        chk("t5_next_pc", ic_pc, 32'h8000_0104);
        respond(mk_line(32'hC000_0000, 32'hC000_0104, 32'hC000_0008, 32'hC000_000C), 64'h0);
        chk("t5_id_inst", id_inst, 32'hC000_0104);
        chk("t5_id_pc2", id_pc, 32'h8000_0104);

        // 4: redirect in HOLD into the uncacheable window
        redirect(32'h0000_1004);
        chk("t4_id_valid", 32'(id_valid), 32'd0);
        chk("t4_ic_pc", ic_pc, 32'h0000_1004);
        chk("t4_ic_unc", 32'(ic_uncacheable), 32'd1);
        respond(mk_line(32'hEEEE_0000, 32'hEEEE_0001, 32'hEEEE_0002, 32'hEEEE_0003),
                64'h1234_5678_8765_4321);
        chk("t4_id_inst", id_inst, 32'h1234_5678);
        chk("t4_id_pc", id_pc, 32'h0000_1004);

        // Redirect beats a same-cycle decode handshake
        id_ready = 1'b1;
        redirect(32'h0000_2000);
        id_ready = 1'b0;
        chk("rw_ic_pc", ic_pc, 32'h0000_2000);
        chk("rw_id_valid", 32'(id_valid), 32'd0);
        respond(128'h0, 64'h1111_1111_AAAA_5555);
        chk("rw_id_inst", id_inst, 32'hAAAA_5555);
        chk("rw_id_pc", id_pc, 32'h0000_2000);

        // PC wrap and low-bit clearing on redirect target
        redirect(32'hFFFF_FFFE);
        chk("wr_ic_pc", ic_pc, 32'hFFFF_FFFC);
        chk("wr_ic_unc", 32'(ic_uncacheable), 32'd0);
        respond(mk_line(32'hD000_0000, 32'hD000_0004, 32'hD000_0008, 32'hD000_000F), 64'h0);
        chk("wr_id_inst", id_inst, 32'hD000_000F);
        id_ready = 1'b1;
        step();
        id_ready = 1'b0;
        chk("wr_ic_pc_wrap", ic_pc, 32'h0000_0000);
        chk("wr_ic_unc_wrap", 32'(ic_uncacheable), 32'd1);

        // Back-to-back redirects in FETCH: last target wins, one response dropped
        redirect(32'h8000_0200);
        redirect(32'h8000_0300);
        respond(mk_line(32'hBAD0_0000, 32'hBAD0_0001, 32'hBAD0_0002, 32'hBAD0_0003), 64'hBAD);
        chk("bb_id_valid", 32'(id_valid), 32'd0);
        chk("bb_ic_pc", ic_pc, 32'h8000_0300);
        respond(mk_line(32'hE000_0300, 32'hE000_0304, 32'hE000_0308, 32'hE000_030C), 64'h0);
        chk("bb_id_pc", id_pc, 32'h8000_0300);
        chk("bb_id_inst", id_inst, 32'hE000_0300);

        // Redirect coinciding with ic_ready drops that response
        id_ready = 1'b1;
        step();
        id_ready = 1'b0;
        chk("rr_ic_pc_pre", ic_pc, 32'h8000_0304);
        ic_inst        = mk_line(32'hBAD1_0000, 32'hBAD1_0001, 32'hBAD1_0002, 32'hBAD1_0003);
        ic_ready       = 1'b1;
        redirect(32'h8000_0408);
        ic_ready       = 1'b0;
        chk("rr_id_valid", 32'(id_valid), 32'd0);
        chk("rr_ic_valid", 32'(ic_valid), 32'd1);
        chk("rr_ic_pc", ic_pc, 32'h8000_0408);
        respond(mk_line(32'hF000_0400, 32'hF000_0404, 32'hF000_0408, 32'hF000_040C), 64'h0);
        chk("rr_id_inst", id_inst, 32'hF000_0408);
        chk("rr_id_pc", id_pc, 32'h8000_0408);

        // 6: reset mid-fetch, ic_ready ignored in reset and IDLE
        id_ready = 1'b1;
        step();
        id_ready = 1'b0;
        chk("t6_fetch_pc", ic_pc, 32'h8000_040C);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_ic_valid", 32'(ic_valid), 32'd0);
        chk("t6_rst_ic_pc", ic_pc, 32'h8000_0000);
        ic_inst  = mk_line(32'hBAD2_0000, 32'hBAD2_0001, 32'hBAD2_0002, 32'hBAD2_0003);
        ic_ready = 1'b1;
        step();
        chk("t6_rst_id_valid", 32'(id_valid), 32'd0);
        rst_n = 1'b1;
        step();
        ic_ready = 1'b0;
        chk("t6_idle_id_valid", 32'(id_valid), 32'd0);
        chk("t6_restart_valid", 32'(ic_valid), 32'd1);
        chk("t6_restart_pc", ic_pc, 32'h8000_0000);
        respond(mk_line(32'h0000_0413, 32'h0, 32'h0, 32'h0), 64'h0);
        chk("t6_id_valid", 32'(id_valid), 32'd1);
        chk("t6_id_inst", id_inst, 32'h0000_0413);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
